sum_deserializer: RTL
=====================

Name: sum_deserializer

Overview:
- Receiving end of the bit-serial datapath in the sequential adder.
- Collects the LSB-first serial sum stream, one bit per accepted cycle, into a WIDTH-bit parallel word, and captures the final carry.
- Presents the word to the downstream consumer over a valid/ready handshake.
- Sits between the serial full-adder stage and the parallel result register/display logic.

Parameters:
- WIDTH, 8, number of sum bits per word (>=2).
- CW, 4, width of the bit counter; must satisfy 2**CW > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins (or restarts) collection of a new word.
- bit_in  input  1  serial sum bit, LSB first.
- bit_valid  input  1  bit_in is valid this cycle.
- bit_ready  output  1  block accepts a bit this cycle.
- cout_in  input  1  adder carry-out; sampled with the final (WIDTH-th) bit.
- sum_out  output  WIDTH  assembled sum word.
- cout_out  output  1  captured final carry.
- out_valid  output  1  sum_out/cout_out hold a complete result.
- out_ready  input  1  consumer takes the result.
- busy  output  1  high in COLLECT.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, count=0.
  - sum_out=0, cout_out=0, out_valid=0, bit_ready=0, busy=0.
  - Takes effect immediately, including mid-collection or mid-hold; a partial word is discarded.
- States: IDLE, COLLECT, HOLD. All outputs are registered or decoded from state only; no combinational input-to-output path.
- IDLE:
  - bit_ready=0; bit_valid is ignored.
  - start=1 -> COLLECT; count=0, shift register cleared.
- COLLECT:
  - bit_ready=1, busy=1.
  - Accept = bit_valid & bit_ready. On accept: shift register shifts right, bit_in enters bit WIDTH-1, count increments.
  - After WIDTH accepts, bit 0 holds the first bit received.
  - Accept with count==WIDTH-1 (final bit):
    - cout_in is captured into cout_out in the same edge.
    - The completed word is loaded into sum_out.
    - Next state HOLD; out_valid=1 from the following cycle.
    - Latency: out_valid rises one clock after the final bit is accepted.
  - Cycles with bit_valid=0 stall without state change.
  - start=1 in COLLECT restarts: count=0, shift register cleared, stays in COLLECT. If a bit is also valid that cycle, it is discarded.
  - sum_out/cout_out keep the previous result while collecting; out_valid stays 0.
- HOLD:
  - out_valid=1, bit_ready=0 (backpressure upstream). sum_out and cout_out are stable until the handshake completes.
  - out_valid & out_ready -> out_valid=0 next cycle, state IDLE.
  - If start=1 in the same cycle as the handshake -> go directly to COLLECT, count=0.
  - start=1 without out_ready in HOLD is ignored (not queued).
- Counter:
  - CW bits; never exceeds WIDTH-1 in COLLECT; returns to 0 on every entry to COLLECT.
  - No wrap-around is reachable; count==WIDTH-1 is the terminal value.
- Simultaneous events:
  - rst_n dominates everything.
  - In COLLECT, start dominates bit acceptance.
  - In HOLD, the handshake and start are evaluated together as above.

Test Plan:
- Basic word: reset, pulse start, send 0xA5 LSB first (1,0,1,0,0,1,0,1) with bit_valid held high and cout_in=1 on the 8th bit, out_ready=1 -> out_valid=1 exactly one cycle after the 8th accept, sum_out=0xA5, cout_out=1; out_valid drops the next cycle, state IDLE.
- Gapped input: send 0x3C with bit_valid deasserted for 2 cycles between bits 3 and 4 -> sum_out=0x3C, count holds during gaps, no spurious out_valid.
- Backpressure: complete word 0xFF, cout_in=0, hold out_ready=0 for 5 cycles while driving bit_valid=1 -> bit_ready=0, sum_out stays 0xFF, cout_out=0, out_valid stays 1; raise out_ready -> out_valid=0 next cycle.
- Restart: send 3 bits, pulse start, then send 0x81 -> sum_out=0x81, with no contribution from the first 3 bits.
- Back-to-back: in the HOLD cycle with out_ready=1, pulse start, then send 0x5A -> enters COLLECT directly, second result sum_out=0x5A.
- Async reset: assert rst_n=0 mid-word (after 4 bits) between clock edges -> outputs clear immediately. After release, start and 0x12 -> sum_out=0x12.

Source files
------------

// File: rtl/sum_deserializer.sv
// Receive side of the bit-serial adder: gathers the LSB-first sum stream into a
// parallel word plus final carry and offers it downstream on a valid/ready handshake.
module sum_deserializer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             cout_in,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_HOLD    = 2'd2;

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [1:0]       w_next_state;
  logic             w_accept;
  logic             w_last;
  logic             w_handshake;
  logic             w_begin;
  logic [WIDTH-1:0] w_shifted;

  // A start pulse in COLLECT wins over a bit offered in the same cycle.
  assign w_accept    = (r_state == S_COLLECT) && bit_valid && !start;
  assign w_last      = w_accept && (r_count == LAST_IDX);
  assign w_handshake = (r_state == S_HOLD) && out_ready;
  assign w_begin     = start && ((r_state == S_IDLE) || (r_state == S_COLLECT) || w_handshake);
  assign w_shifted   = {bit_in, r_shift[WIDTH-1:1]};

  always_comb begin
    // NOTE: default first so every path assigns w_next_state; no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_begin) w_next_state = S_COLLECT;
      end
      S_COLLECT: begin
        if (!w_begin && w_last) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (w_begin)          w_next_state = S_COLLECT;
        else if (w_handshake) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_begin) begin
        r_count <= '0;
        r_shift <= '0;
      end else if (w_last) begin
        r_count <= '0;
        r_shift <= w_shifted;
        r_sum   <= w_shifted;
        r_cout  <= cout_in;
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
        r_shift <= w_shifted;
      end
    end
  end

  // Every output is a register or a pure decode of the state register.
  assign sum_out   = r_sum;
  assign cout_out  = r_cout;
  assign out_valid = (r_state == S_HOLD);
  assign bit_ready = (r_state == S_COLLECT);
  assign busy      = (r_state == S_COLLECT);

`ifndef SYNTHESIS
  a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_COLLECT) |-> (r_count <= LAST_IDX));
  a_legal_state: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != 2'd3));
`endif

endmodule
